mult_feed_for_1409: RTL

//   Iterative shift-add multiplier: the stage directly upstream of barret_for_1409.

---
 rtl/barret_1409_pkg.sv | 16 +
 rtl/mult_feed_for_1409_if.sv | 25 ++
 rtl/mult_feed_for_1409.sv | 114 +++++++++++
 3 files changed

// File: rtl/barret_1409_pkg.sv
// Shared constants and state encoding for the mod-1409 arithmetic chain
// (mult_feed_for_1409, barret_for_1409 and their benches).
package barret_1409_pkg;

  localparam int unsigned Q  = 1409;
  localparam int unsigned W  = 11;
  localparam int unsigned PW = 21;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_feed_for_1409_if.sv
// Operand/product handshake bundle for mult_feed_for_1409.
// The slave modport is the multiplier side; master is the driver/consumer side.
interface mult_feed_for_1409_if;
  import barret_1409_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_prod;
  logic          out_err;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod, out_err
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod, out_err
  );

endinterface

// File: rtl/mult_feed_for_1409.sv
// Iterative shift-add multiplier producing the raw 21-bit a*b for barret_for_1409.
// Define OPERAND_CHECK_EN to flag operands >= Q on out_err.
module mult_feed_for_1409
  import barret_1409_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  mult_feed_for_1409_if.slave  bus
);

  localparam logic [1:0]    S_IDLE   = IDLE;
  localparam logic [1:0]    S_BUSY   = BUSY;
  localparam logic [1:0]    S_DONE   = DONE;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q;
  logic          in_take;
  logic          out_take;

  // rdy_q keeps in_ready low while reset is held, even though state is IDLE.
  assign bus.in_ready  = rdy_q & ((state_q == S_IDLE) |
                                  ((state_q == S_DONE) & bus.out_ready));
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_prod  = acc_q;
  assign in_take       = bus.in_valid & bus.in_ready;
  assign out_take      = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_BUSY: begin
        // b is consumed LSB-first while a shifts left, so b_q[0] is b[cnt].
        if (b_q[0]) begin
          acc_d = acc_q + a_q;
        end
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_IDLE, S_DONE: begin
        if (out_take) begin
          state_d = S_IDLE;
        end
        if (in_take) begin
          a_d     = {{(PW-W){1'b0}}, bus.in_a};
          b_d     = bus.in_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
    end
  end

`ifdef OPERAND_CHECK_EN
  localparam logic [W-1:0] QW = W'(Q);

  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (out_take) begin
      err_d = 1'b0;
    end
    if (in_take) begin
      err_d = (bus.in_a >= QW) | (bus.in_b >= QW);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.out_err = err_q;
`else
  assign bus.out_err = 1'b0;
`endif

endmodule
